// File: rtl/midi_uart_rx.sv
// MIDI serial receiver: 16x oversampled 8N1 deframer feeding a small byte FIFO.
// Frames with a low stop bit are dropped with an error pulse; bytes that find the FIFO full are dropped with an overrun pulse.
module midi_uart_rx #(
    parameter int CLK_FREQ   = 16_000_000,
    parameter int BAUD       = 31_250,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          midi_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          frame_err_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic             sync1_q, sync2_q, rx_prev_q;
    logic             rx_s;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    state_t           state_q, state_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             start_edge, push;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop, full, accept;

    assign rx_s = sync2_q;
    assign tick = (div_q == DIV_W'(DIV - 1));

    // Synchroniser and edge-history flops reset high so releasing reset never looks like a start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= midi_i;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        start_edge  = 1'b0;
        push        = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    start_edge = 1'b1;
                    state_d    = S_START;
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = 4'd0;
                        state_d    = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = 4'd0;
                        shift_d    = {rx_s, shift_q[7:1]};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tick_cnt_q == 4'd15) begin
                        tick_cnt_d = 4'd0;
                        if (rx_s) begin
                            push    = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The divider restarts on a start edge so the start-bit midpoint lands 8 ticks later.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (start_edge || tick) div_d = '0;
    end

    assign valid_o = (level_q != '0);
    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop     = valid_o && ready_i;
    assign accept  = push && (!full || pop);

    always_comb begin
        overrun_d = push && full && !pop;
        wr_ptr_d  = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d   = level_q;
        if (accept && !pop)      level_d = level_q + LVL_W'(1);
        else if (!accept && pop) level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q       <= '0;
            state_q     <= S_IDLE;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
        end
    end

    // NOTE: the storage is cleared on reset because data_o reads it directly and must show 0x00 out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (accept) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign data_o      = mem_q[rd_ptr_q];
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign level_o     = level_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Scoreboard bench for midi_uart_rx: the driver queues the bytes a MIDI line should deliver,
// and a monitor pops and compares them whenever the consumer accepts a byte.
`timescale 1ns/1ps
module tb_midi_uart_rx;

    localparam int CLK_FREQ = 2_000_000;
    localparam int BAUD     = 31_250;
    localparam int DEPTH    = 4;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;   // 64 clocks per MIDI bit
    localparam int LW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, midi, ready;
    logic [7:0]    data_o;
    logic          valid_o, frame_err_o, overrun_o;
    logic [LW-1:0] level_o;

    int         total = 0;
    int         bad   = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] exp_q[$];
    bit         rand_ready = 1'b0;

    midi_uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .midi_i     (midi),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o),
        .level_o    (level_o)
    );

    always #250 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples well after the falling edge, where the driver has already settled its inputs.
    always @(negedge clk) begin
        #10;
        if (!rst) begin
            if (frame_err_o) fe_cnt++;
            if (overrun_o)   ov_cnt++;
            if (valid_o && ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected no byte", data_o);
                end else begin
                    check("pop_data", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    endtask

    // 8N1 frame, LSB first; a bad stop bit leaves the line low for the caller to release.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit expect_out);
        if (stop_ok && expect_out) exp_q.push_back(b);
        midi = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            midi = b[i];
            wait_clks(BIT_CLKS);
        end
        midi = stop_ok;
        wait_clks(BIT_CLKS);
        if (stop_ok) midi = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        ready = 1'b1;
        n = 0;
        while (valid_o && n < 50) begin
            wait_clks(1);
            n++;
        end
        wait_clks(2);
        check({name, "_valid_low"}, {31'h0, valid_o}, 32'd0);
        check({name, "_scoreboard_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0, ov0, lat;
        logic [7:0] b;
        logic [7:0] aa;

        rst = 1'b1; midi = 1'b1; ready = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(1);
        check("rst_valid",     {31'h0, valid_o},     32'd0);
        check("rst_level",     {29'h0, level_o},     32'd0);
        check("rst_frame_err", {31'h0, frame_err_o}, 32'd0);
        check("rst_overrun",   {31'h0, overrun_o},   32'd0);
        check("rst_data",      {24'h0, data_o},      32'h00);

        // Single byte with latency measurement from the start edge.
        ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt;
        lat = 0;
        fork
            send_byte(8'h90, 1'b1, 1'b1);
            begin
                while (!valid_o && lat < 2000) begin
                    wait_clks(1);
                    lat++;
                end
            end
        join
        check("single_latency_window", {31'h0, (lat >= 600 && lat <= 620)}, 32'd1);
        wait_clks(20);
        check("single_no_frame_err", fe_cnt - fe0, 32'd0);
        check("single_no_overrun",   ov_cnt - ov0,  32'd0);
        drain("single");

        // Short glitch on an idle line.
        fe0 = fe_cnt;
        midi = 1'b0;
        wait_clks(8);
        midi = 1'b1;
        wait_clks(700);
        check("glitch_valid",     {31'h0, valid_o}, 32'd0);
        check("glitch_frame_err", fe_cnt - fe0,     32'd0);

        // Bad stop bit followed by a 2 ms break, then a good byte.
        fe0 = fe_cnt;
        send_byte(8'h3C, 1'b0, 1'b0);
        wait_clks(4000);
        midi = 1'b1;
        wait_clks(100);
        check("framing_one_pulse", fe_cnt - fe0,     32'd1);
        check("framing_no_byte",   {31'h0, valid_o}, 32'd0);
        send_byte(8'h45, 1'b1, 1'b1);
        wait_clks(20);
        check("framing_no_extra_pulse", fe_cnt - fe0, 32'd1);
        drain("framing");

        // Overrun: five bytes into a four-deep FIFO with no consumer.
        ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, i <= 4);
        wait_clks(20);
        check("overrun_level", {29'h0, level_o}, 32'd4);
        check("overrun_pulse", ov_cnt - ov0,     32'd1);
        drain("overrun");

        // Full FIFO with a pop exactly in the cycle 0x7F is pushed.
        ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, 1'b1);
            wait_clks($urandom_range(1, 30));
        end
        check("fullpop_level_before", {29'h0, level_o}, 32'd4);
        fork
            send_byte(8'h7F, 1'b1, 1'b1);
            begin
                // Push lands in the cycle after the 610th rising edge from the start drive.
                wait_clks(610);
                ready = 1'b1;
                wait_clks(1);
                ready = 1'b0;
            end
        join
        wait_clks(5);
        check("fullpop_level_after", {29'h0, level_o}, 32'd4);
        check("fullpop_no_overrun",  ov_cnt - ov0,     32'd0);
        drain("fullpop");

        // Random bytes with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_clks($urandom_range(1, 80));
            send_byte(8'($urandom), 1'b1, 1'b1);
        end
        rand_ready = 1'b0;
        drain("random");

        // Reset in the middle of data bit 3 of 0xAA, with a byte already buffered.
        ready = 1'b0;
        send_byte(8'h12, 1'b1, 1'b1);
        wait_clks(10);
        aa = 8'hAA;
        midi = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            midi = aa[i];
            wait_clks(BIT_CLKS);
        end
        midi = aa[3];
        wait_clks(BIT_CLKS / 2);
        rst = 1'b1;
        exp_q.delete();
        wait_clks(3);
        midi = 1'b1;
        rst = 1'b0;
        wait_clks(2);
        check("midrst_valid", {31'h0, valid_o}, 32'd0);
        check("midrst_level", {29'h0, level_o}, 32'd0);
        check("midrst_data",  {24'h0, data_o},  32'h00);
        wait_clks(200);
        check("midrst_no_byte", {31'h0, valid_o}, 32'd0);
        send_byte(8'h55, 1'b1, 1'b1);
        wait_clks(20);
        check("midrst_next_level", {29'h0, level_o}, 32'd1);
        drain("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
